// File: rtl/note_source_pkg.sv
// note_source_pkg: widths, default beat length, FSM state type and the
// silence code shared by note_source and note_phase_acc.
package note_source_pkg;

  localparam int PHASE_W          = 20;
  localparam int SAMPLE_W         = 16;
  localparam int DUR_W            = 6;
  localparam int BEAT_SAMPLES_DEF = 4;

  localparam logic [SAMPLE_W-1:0] SILENCE = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/note_phase_acc.sv
// note_phase_acc: 20-bit phase accumulator plus registered wave shaping.
// Build option NOTE_SOURCE_SQUARE_EN swaps the triangle shaper for a
// +/-16384 square wave; timing is identical either way.
module note_phase_acc
  import note_source_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,    // new note: phase back to zero
  input  logic                advance,  // step the phase and emit a shaped sample
  input  logic                answer,   // request that does not advance: emit silence
  input  logic [PHASE_W-1:0]  step,
  output logic [SAMPLE_W-1:0] sample
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;

  // Wraps mod 2^20 by width truncation.
  assign phase_next = phase + step;

`ifdef NOTE_SOURCE_SQUARE_EN
  function automatic logic [SAMPLE_W-1:0] shape(input logic [PHASE_W-1:0] ph);
    return ph[PHASE_W-1] ? 16'hC000 : 16'h4000;
  endfunction
`else
  // Fold the upper half of the cycle back down, then flip the MSB so the
  // unsigned ramp lands on the signed -32768..32767 range.
  function automatic logic [SAMPLE_W-1:0] shape(input logic [PHASE_W-1:0] ph);
    logic [SAMPLE_W-1:0] t;
    t = ph[PHASE_W-1] ? ~ph[PHASE_W-2:3] : ph[PHASE_W-2:3];
    return t ^ 16'h8000;
  endfunction
`endif

  // Phase register and sample register; sample is shaped from the
  // post-increment phase so the first sample of a note is shape(step).
  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= '0;
      sample <= SILENCE;
    end else begin
      if (clear)
        phase <= '0;
      else if (advance)
        phase <= phase_next;

      if (advance)
        sample <= shape(phase_next);
      else if (answer)
        sample <= SILENCE;
    end
  end

endmodule

// File: rtl/note_source.sv
// note_source: one-note-at-a-time sample source. Holds the IDLE/PLAY/DONE
// FSM, the beat divider (BEAT_SAMPLES requests per beat), the beat counter
// and the output strobes. Optional macro: NOTE_SOURCE_SQUARE_EN (square
// wave instead of triangle, handled inside note_phase_acc).
module note_source
  import note_source_pkg::*;
#(
  parameter int BEAT_SAMPLES = BEAT_SAMPLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_note,
  input  logic [PHASE_W-1:0]  note_step,
  input  logic [DUR_W-1:0]    note_duration_in,
  input  logic                play_enable,
  input  logic                generate_next_sample,
  output logic                note_ready,
  output logic [DUR_W-1:0]    note_duration,
  output logic [SAMPLE_W-1:0] sample,
  output logic                new_sample_ready,
  output logic                done_with_note,
  output logic                note_active
);

  localparam int DIV_W = (BEAT_SAMPLES < 2) ? 1 : $clog2(BEAT_SAMPLES + 1);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(BEAT_SAMPLES);

  state_t             state;
  logic [PHASE_W-1:0] step_q;
  logic [DIV_W-1:0]   div;
  logic [DUR_W-1:0]   beat;

  logic               accept;
  logic               advance;
  logic [DIV_W-1:0]   div_inc;
  logic [DUR_W-1:0]   beat_inc;

  assign accept   = (state == IDLE) && load_note;
  assign advance  = (state == PLAY) && generate_next_sample && play_enable;
  assign div_inc  = div + 1'b1;
  assign beat_inc = beat + 1'b1;

  // Every request is answered one cycle later, advancing or not.
  always_ff @(posedge clk) begin
    if (reset)
      new_sample_ready <= 1'b0;
    else
      new_sample_ready <= generate_next_sample;
  end

  // Note FSM with registered status outputs, beat divider and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      step_q         <= '0;
      note_duration  <= '0;
      div            <= '0;
      beat           <= '0;
      note_ready     <= 1'b1;
      note_active    <= 1'b0;
      done_with_note <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_with_note <= 1'b0;
          if (load_note) begin
            step_q        <= note_step;
            note_duration <= note_duration_in;
            div           <= '0;
            beat          <= '0;
            note_ready    <= 1'b0;
            if (note_duration_in == '0) begin
              // Zero-length note: straight to the end-of-note pulse.
              state          <= DONE;
              done_with_note <= 1'b1;
            end else begin
              state       <= PLAY;
              note_active <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (advance) begin
            if (div_inc == DIV_TOP) begin
              div  <= '0;
              beat <= beat_inc;
              if (beat_inc == note_duration) begin
                state          <= DONE;
                note_active    <= 1'b0;
                done_with_note <= 1'b1;
              end
            end else begin
              div <= div_inc;
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          done_with_note <= 1'b0;
          note_ready     <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          note_ready     <= 1'b1;
          note_active    <= 1'b0;
          done_with_note <= 1'b0;
        end
      endcase
    end
  end

  note_phase_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (advance),
    .answer  (generate_next_sample),
    .step    (step_q),
    .sample  (sample)
  );

endmodule

// File: tb/tb_note_source.sv
// tb_note_source: directed steps plus a randomized run, every cycle checked
// against a note-level reference model (requests-advanced count, phase as
// an integer, waveform from its arithmetic definition).
module tb_note_source;

  localparam int BS = 4;

  logic        clk = 1'b0;
  logic        reset, load_note, play_enable, generate_next_sample;
  logic [19:0] note_step;
  logic [5:0]  note_duration_in;
  logic        note_ready, new_sample_ready, done_with_note, note_active;
  logic [5:0]  note_duration;
  logic [15:0] sample;

  note_source #(.BEAT_SAMPLES(BS)) dut (
    .clk                  (clk),
    .reset                (reset),
    .load_note            (load_note),
    .note_step            (note_step),
    .note_duration_in     (note_duration_in),
    .play_enable          (play_enable),
    .generate_next_sample (generate_next_sample),
    .note_ready           (note_ready),
    .note_duration        (note_duration),
    .sample               (sample),
    .new_sample_ready     (new_sample_ready),
    .done_with_note       (done_with_note),
    .note_active          (note_active)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;

  // Reference model: mode 0 idle, 1 playing, 2 done.
  int          m_mode = 0;
  int unsigned m_phase = 0, m_step = 0, m_adv = 0;
  int          m_dur = 0;
  logic [15:0] m_sample = 16'h0;
  logic        m_nsr = 1'b0;

  function automatic logic [15:0] shape(input int unsigned ph);
`ifdef NOTE_SOURCE_SQUARE_EN
    return (ph >= 32'h80000) ? 16'hC000 : 16'h4000;
`else
    int unsigned t;
    t = (ph / 8) % 65536;
    if (ph >= 32'h80000) t = 65535 - t;
    return 16'(t ^ 32'h8000);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model across the edge, check outputs.
  task automatic tick(input bit ld, input logic [19:0] st, input logic [5:0] du,
                      input bit en, input bit rq, input bit rs);
    int old_mode;
    reset = rs; load_note = ld; note_step = st; note_duration_in = du;
    play_enable = en; generate_next_sample = rq;
    @(posedge clk);
    old_mode = m_mode;
    if (rs) begin
      m_mode = 0; m_phase = 0; m_step = 0; m_adv = 0; m_dur = 0;
      m_sample = 16'h0; m_nsr = 1'b0;
    end else begin
      m_nsr = rq;
      if (rq) begin
        if (old_mode == 1 && en) begin
          m_phase  = (m_phase + m_step) % 32'h100000;
          m_sample = shape(m_phase);
          m_adv++;
          if (m_adv == m_dur * BS) m_mode = 2;
        end else begin
          m_sample = 16'h0;
        end
      end
      if (old_mode == 0 && ld) begin
        m_step = st; m_dur = du; m_phase = 0; m_adv = 0;
        m_mode = (du == 0) ? 2 : 1;
      end else if (old_mode == 2) begin
        m_mode = 0;
      end
    end
    #1;
    if (done_with_note === 1'b1) done_cnt++;
    chk("sample",           32'(sample),           32'(m_sample));
    chk("new_sample_ready", 32'(new_sample_ready), 32'(m_nsr));
    chk("done_with_note",   32'(done_with_note),   32'(m_mode == 2));
    chk("note_ready",       32'(note_ready),       32'(m_mode == 0));
    chk("note_active",      32'(note_active),      32'(m_mode == 1));
    chk("note_duration",    32'(note_duration),    32'(m_dur));
  endtask

  task automatic idle_cycle();
    tick(0, 20'h0, 6'd0, 1, 0, 0);
  endtask

  initial begin
    // Reset state and a request answered with silence.
    tick(0, 20'h0, 6'd0, 1, 0, 1);
    tick(0, 20'h0, 6'd0, 1, 0, 1);
    chk("reset_note_ready", 32'(note_ready), 32'd1);
    chk("reset_sample", 32'(sample), 32'd0);
    tick(0, 20'h0, 6'd0, 1, 1, 0);
    chk("idle_req_nsr", 32'(new_sample_ready), 32'd1);
    chk("idle_req_sample", 32'(sample), 32'h0000);

    // Step 0x08000, 2 beats, eight spaced requests.
    tick(1, 20'h08000, 6'd2, 1, 0, 0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 20'h0, 6'd0, 1, 1, 0);
      if (i == 0) begin
`ifdef NOTE_SOURCE_SQUARE_EN
        chk("first_sample", 32'(sample), 32'h4000);
`else
        chk("first_sample", 32'(sample), 32'h9000);
`endif
      end
      if (i == 7) chk("done_on_8th", 32'(done_with_note), 32'd1);
      if (i < 7) for (int k = 0; k < 9; k++) idle_cycle();
    end
    idle_cycle();
    chk("ready_after_done", 32'(note_ready), 32'd1);
    chk("done_count", 32'(done_cnt), 32'd1);

    // Phase wrap with step 0x60000.
    tick(1, 20'h60000, 6'd5, 1, 0, 0);
`ifdef NOTE_SOURCE_SQUARE_EN
    tick(0, 20'h0, 6'd0, 1, 1, 0); chk("wrap0", 32'(sample), 32'h4000);
    tick(0, 20'h0, 6'd0, 1, 1, 0); chk("wrap1", 32'(sample), 32'hC000);
    tick(0, 20'h0, 6'd0, 1, 1, 0); chk("wrap2", 32'(sample), 32'h4000);
`else
    tick(0, 20'h0, 6'd0, 1, 1, 0); chk("wrap0", 32'(sample), 32'h4000);
    tick(0, 20'h0, 6'd0, 1, 1, 0); chk("wrap1", 32'(sample), 32'hFFFF);
    tick(0, 20'h0, 6'd0, 1, 1, 0); chk("wrap2", 32'(sample), 32'hC000);
`endif
    // Load during PLAY ignored, then reset mid-note.
    tick(1, 20'h12345, 6'd7, 1, 0, 0);
    chk("load_in_play_dur", 32'(note_duration), 32'd5);
    done_cnt = 0;
    tick(0, 20'h0, 6'd0, 1, 1, 1);
    chk("midreset_ready", 32'(note_ready), 32'd1);
    chk("midreset_nsr", 32'(new_sample_ready), 32'd0);
    idle_cycle();
    chk("midreset_no_done", 32'(done_cnt), 32'd0);

    // Duration 0, with a request in the load cycle and one in DONE.
    tick(1, 20'h11111, 6'd0, 1, 1, 0);
    chk("dur0_done", 32'(done_with_note), 32'd1);
    chk("dur0_sample", 32'(sample), 32'h0000);
    tick(0, 20'h0, 6'd0, 1, 1, 0);
    chk("dur0_sample2", 32'(sample), 32'h0000);
    chk("dur0_back_idle", 32'(note_ready), 32'd1);

    // Pause mid-beat, then resume.
    tick(1, 20'h01000, 6'd1, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 20'h0, 6'd0, 1, 1, 0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 20'h0, 6'd0, 0, 1, 0);
      chk("pause_sample", 32'(sample), 32'h0000);
    end
    chk("pause_no_done", 32'(done_cnt), 32'd0);
    tick(0, 20'h0, 6'd0, 1, 1, 0);
    chk("resume_done", 32'(done_with_note), 32'd1);
    idle_cycle();

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 9) == 0), 20'($urandom), 6'($urandom_range(0, 3)),
           ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
